dmem_rmw_ctrl: RTL and testbench
================================

Name: dmem_rmw_ctrl

Overview:
- Sequences M-stage data-memory accesses onto a single-port synchronous SRAM that has no byte enables.
- Sits between the data aligner's memory interface (word address, lane-positioned write data, 4-bit write strobe, read request) and the SRAM.
- Full-word stores are issued directly. Sub-word stores are turned into a read-merge-write sequence.
- Stalls the pipeline for as long as each access needs.

Parameters:
- RAM_LAT, 1, SRAM read latency in cycles from address/RE to valid RAM_RDATA; legal range 1..3.
- AW, 30, SRAM word-address width (bits [AW+1:2] of the byte address are used).

Ports:
- CLK  in  1  system clock, rising edge
- RST_X  in  1  asynchronous active-low reset
- MADDR  in  30  word address [31:2] from the aligner
- MDATAO  in  32  write data, already lane-positioned by the aligner; lane 3 = bits 31:24
- MWSTB  in  4  write strobe; bit n enables lane n; 0000 = no write
- MRE  in  1  read request (aligner RE != 0)
- MDATAI  out  32  read data to the aligner
- STALL  out  1  holds the pipeline; the requester keeps all inputs stable while STALL=1
- RAM_ADDR  out  AW  SRAM word address
- RAM_WDATA  out  32  SRAM write data
- RAM_WE  out  1  SRAM write enable (whole word)
- RAM_RE  out  1  SRAM read enable
- RAM_RDATA  in  32  SRAM read data, valid RAM_LAT cycles after RAM_RE

Behaviour:
- Reset values (async, RST_X=0): state=IDLE, wait counter=0, latched address/data/strobe=0. Outputs: STALL=0, RAM_WE=0, RAM_RE=0, MDATAI=0.
- States: IDLE, RWAIT, RDONE, MWAIT, MWRITE.
- Request classification in IDLE, in priority order:
  1. WSTB=1111 → full write
  2. WSTB≠0000 → partial write
  3. MRE=1 → read
  4. otherwise no access
- A request with both MRE and WSTB≠0 is treated as a write; MRE is ignored.
- IDLE, no access: RAM_WE=0, RAM_RE=0, STALL=0, MDATAI=0.
- IDLE, full write:
  - RAM_ADDR=MADDR[AW-1:0], RAM_WDATA=MDATAO, RAM_WE=1, STALL=0.
  - Completes in the same cycle; stay in IDLE.
- IDLE, read:
  - Drive RAM_ADDR, RAM_RE=1, STALL=1.
  - Latch address; load wait counter with RAM_LAT-1.
  - Go to RWAIT if RAM_LAT>1, else RDONE.
- RWAIT: STALL=1, RAM_RE=0. Decrement the counter; at 1 go to RDONE.
- RDONE:
  - MDATAI=RAM_RDATA (combinational), STALL=0, go to IDLE.
  - Load latency = RAM_LAT+1 cycles, including the request cycle.
- IDLE, partial write:
  - Drive RAM_ADDR, RAM_RE=1, STALL=1.
  - Latch address, MDATAO and WSTB; load the counter.
  - Go to MWAIT if RAM_LAT>1, else MWRITE.
- MWAIT: same counting as RWAIT; then go to MWRITE.
- MWRITE:
  - For each lane n: RAM_WDATA lane n = latched WSTB[n] ? latched data lane n : RAM_RDATA lane n.
  - RAM_ADDR = latched address, RAM_WE=1, STALL=0, go to IDLE.
  - Partial-store latency = RAM_LAT+1 cycles.
- Latched copies are used for RAM_ADDR/RAM_WDATA in every non-IDLE state, so input glitches after the request cycle have no effect.
- While STALL=0 in RDONE/MWRITE, the pipeline advances at the clock edge. The next request is sampled in the following IDLE cycle, which gives back-to-back service with no bubble beyond the latency above.
- At most one of RAM_WE and RAM_RE is asserted in any cycle.
- Address wrap: only the low AW bits are used; upper bits are ignored, so no fault is raised.
- Reset mid-sequence: an in-flight partial write is abandoned without any SRAM write, and STALL drops immediately.
- RAM_LAT outside 1..3 is a static configuration error: elaboration-time check fails.

Decomposition:
- Shared package/header (riscv.vh): state encodings (IDLE=0 … MWRITE=4), WSTB_NONE=4'b0000, WSTB_WORD=4'b1111.
- One natural sub-module: rmw_lane_merge, a combinational 4-lane byte mux (latched strobe, latched data, RAM_RDATA → merged word). It is reusable by a future store buffer.

Test Plan:
- Full write, RAM_LAT=1: MADDR=0x10, MDATAO=0xDEADBEEF, WSTB=1111 → RAM_WE=1 same cycle, STALL never 1; a later read of 0x10 returns 0xDEADBEEF two cycles after the request.
- Byte store: word 0x20 preloaded 0x11223344; WSTB=0100, MDATAO=0x00AA0000 → cycle0 RAM_RE=1, STALL=1; cycle1 RAM_WE=1, RAM_WDATA=0x11AA3344, STALL=0.
- Half-word store at RAM_LAT=3: WSTB=0011, MDATAO=0x0000BBCC on word 0x11223344 → STALL high for 3 cycles; 4th cycle writes 0x1122BBCC.
- Back-to-back: read 0x20 immediately followed by full write 0x24 → read data valid in RDONE; the write is issued in the next IDLE cycle; no lost or duplicated access.
- Simultaneous MRE=1 and WSTB=0001 → treated as a partial write; RDONE is never entered and MDATAI stays 0.
- Reset asserted during MWAIT (RAM_LAT=2) → STALL=0 and RAM_WE=0 immediately; the SRAM word is unchanged after reset release.

Source files
------------

// File: rtl/dmem_rmw_ctrl_pkg.sv
// rtl/dmem_rmw_ctrl_pkg.sv - shared encodings for the data-memory read-merge-write controller
package dmem_rmw_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RWAIT  = 3'd1,
    RDONE  = 3'd2,
    MWAIT  = 3'd3,
    MWRITE = 3'd4
  } rmw_state_t;

  localparam logic [3:0] WSTB_NONE = 4'b0000;
  localparam logic [3:0] WSTB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_FULL = 2'd1,
    REQ_PART = 2'd2,
    REQ_READ = 2'd3
  } req_kind_t;

  // Any non-zero strobe makes it a write; MRE only matters when nothing is written.
  function automatic req_kind_t classify(input logic [3:0] wstb, input logic re);
    if (wstb == WSTB_WORD) return REQ_FULL;
    if (wstb != WSTB_NONE) return REQ_PART;
    if (re)                return REQ_READ;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_lane_merge.sv
// rtl/dmem_rmw_ctrl_lane_merge.sv - per-byte mux of store data over the word read back from SRAM
module dmem_rmw_ctrl_lane_merge (
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  // Strobed lanes take the new store data, the rest keep the old memory contents.
  always_comb begin
    merged = rdata;
    for (int n = 0; n < 4; n++) begin
      if (strb[n]) merged[n*8 +: 8] = wdata[n*8 +: 8];
    end
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// rtl/dmem_rmw_ctrl.sv - sequences M-stage loads/stores onto a byte-enable-less single-port SRAM
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int AW      = 30
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [29:0]   MADDR,
  input  logic [31:0]   MDATAO,
  input  logic [3:0]    MWSTB,
  input  logic          MRE,
  output logic [31:0]   MDATAI,
  output logic          STALL,
  output logic [AW-1:0] RAM_ADDR,
  output logic [31:0]   RAM_WDATA,
  output logic          RAM_WE,
  output logic          RAM_RE,
  input  logic [31:0]   RAM_RDATA
);

  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_ram_lat
    $error("dmem_rmw_ctrl: RAM_LAT must be within 1..3");
  end

  localparam logic [1:0] LAT_M1   = 2'(RAM_LAT - 1);
  localparam bit         MULTICYC = (RAM_LAT > 1);

  rmw_state_t    state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic          capture;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_data;
  logic [3:0]    lat_strb;
  logic [31:0]   merged;
  req_kind_t     req;

  assign req = classify(MWSTB, MRE);

  dmem_rmw_ctrl_lane_merge u_merge (
    .strb   (lat_strb),
    .wdata  (lat_data),
    .rdata  (RAM_RDATA),
    .merged (merged)
  );

  // State, latency counter and the request copy held for the rest of the sequence.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      lat_addr <= '0;
      lat_data <= 32'd0;
      lat_strb <= WSTB_NONE;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        lat_addr <= MADDR[AW-1:0];
        lat_data <= MDATAO;
        lat_strb <= MWSTB;
      end
    end
  end

  // Next state and SRAM/pipeline outputs; all strobes are forced low while reset is held.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture   = 1'b0;
    STALL     = 1'b0;
    RAM_WE    = 1'b0;
    RAM_RE    = 1'b0;
    MDATAI    = 32'd0;
    RAM_ADDR  = lat_addr;
    RAM_WDATA = lat_data;
    case (state)
      IDLE: begin
        RAM_ADDR  = MADDR[AW-1:0];
        RAM_WDATA = MDATAO;
        case (req)
          REQ_FULL: RAM_WE = 1'b1;
          REQ_PART: begin
            RAM_RE   = 1'b1;
            STALL    = 1'b1;
            capture  = 1'b1;
            cnt_nx   = LAT_M1;
            state_nx = MULTICYC ? MWAIT : MWRITE;
          end
          REQ_READ: begin
            RAM_RE   = 1'b1;
            STALL    = 1'b1;
            capture  = 1'b1;
            cnt_nx   = LAT_M1;
            state_nx = MULTICYC ? RWAIT : RDONE;
          end
          default: ;
        endcase
      end
      RWAIT: begin
        STALL  = 1'b1;
        cnt_nx = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = RDONE;
      end
      RDONE: begin
        MDATAI   = RAM_RDATA;
        state_nx = IDLE;
      end
      MWAIT: begin
        STALL  = 1'b1;
        cnt_nx = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = MWRITE;
      end
      MWRITE: begin
        RAM_WDATA = merged;
        RAM_WE    = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!RST_X) begin
      STALL  = 1'b0;
      RAM_WE = 1'b0;
      RAM_RE = 1'b0;
      MDATAI = 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb/tb_dmem_rmw_ctrl.sv - self-checking bench for dmem_rmw_ctrl at SRAM latencies 1, 2 and 3
module tb_dmem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] maddr [3];
  logic [31:0] mdatao [3];
  logic [3:0]  mwstb [3];
  logic        mre [3];
  logic [31:0] mdatai [3];
  logic        stall [3];
  logic [7:0]  ram_addr [3];
  logic [31:0] ram_wdata [3];
  logic        ram_we [3];
  logic        ram_re [3];
  logic [31:0] ram_rdata [3];

  bit   [31:0] sram [3][256];
  bit   [31:0] emem [3][256];
  logic [31:0] rpipe [3][3];

  logic        pl_en = 1'b0;
  int          pl_k;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;

  int          checks = 0;
  int          failures = 0;
  logic        chk_en = 1'b0;
  int          chk_k = 0;
  logic        exp_stall, exp_we, exp_re;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata, exp_mdatai;
  int          stall_cnt;
  logic [31:0] last_mdatai;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_rmw_ctrl #(.RAM_LAT(g + 1), .AW(8)) u_dut (
      .CLK       (clk),
      .RST_X     (rst_n),
      .MADDR     (maddr[g]),
      .MDATAO    (mdatao[g]),
      .MWSTB     (mwstb[g]),
      .MRE       (mre[g]),
      .MDATAI    (mdatai[g]),
      .STALL     (stall[g]),
      .RAM_ADDR  (ram_addr[g]),
      .RAM_WDATA (ram_wdata[g]),
      .RAM_WE    (ram_we[g]),
      .RAM_RE    (ram_re[g]),
      .RAM_RDATA (ram_rdata[g])
    );
    assign ram_rdata[g] = rpipe[g][g];
  end

  // SRAM models: read data appears exactly RAM_LAT edges after RE, garbage otherwise.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ram_we[g]) sram[g][ram_addr[g]] <= ram_wdata[g];
      rpipe[g][0] <= ram_re[g] ? sram[g][ram_addr[g]] : 32'hBAD0_BAD0;
      rpipe[g][1] <= rpipe[g][0];
      rpipe[g][2] <= rpipe[g][1];
    end
    if (pl_en) sram[pl_k][pl_a] <= pl_d;
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the selected instance against the transaction model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", chk_k, 32'(stall[chk_k]), 32'(exp_stall));
      check("ram_we", chk_k, 32'(ram_we[chk_k]), 32'(exp_we));
      check("ram_re", chk_k, 32'(ram_re[chk_k]), 32'(exp_re));
      check("mdatai", chk_k, mdatai[chk_k], exp_mdatai);
      if (exp_we || exp_re) check("ram_addr", chk_k, 32'(ram_addr[chk_k]), 32'(exp_addr));
      if (exp_we) check("ram_wdata", chk_k, ram_wdata[chk_k], exp_wdata);
      if (stall[chk_k]) stall_cnt++;
      last_mdatai = mdatai[chk_k];
    end
  end

  task automatic set_in(input int k, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic re);
    maddr[k]  = a;
    mdatao[k] = d;
    mwstb[k]  = s;
    mre[k]    = re;
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [31:0] d);
    pl_k = k; pl_a = a; pl_d = d; pl_en = 1'b1;
    emem[k][a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One access as the requester sees it: n cycles, inputs held, expectations from plain rules.
  task automatic run_op(input int k, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic re, input bit glitch);
    bit full, part, rd;
    int n;
    logic [31:0] old, merged;
    full = (s == 4'hF);
    part = !full && (s != 4'h0);
    rd   = !full && !part && re;
    old  = emem[k][a[7:0]];
    for (int b = 0; b < 4; b++) merged[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    n = (part || rd) ? (k + 1) + 1 : 1;
    stall_cnt = 0;
    chk_k = k;
    for (int c = 0; c < n; c++) begin
      if (glitch && c > 0) set_in(k, ~a, ~d, ~s, ~re);
      else                 set_in(k, a, d, s, re);
      exp_stall  = (c < n - 1);
      exp_re     = (part || rd) && (c == 0);
      exp_we     = full || (part && c == n - 1);
      exp_addr   = a[7:0];
      exp_wdata  = full ? d : merged;
      exp_mdatai = (rd && c == n - 1) ? old : 32'd0;
      chk_en = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
    if (full)      emem[k][a[7:0]] = d;
    else if (part) emem[k][a[7:0]] = merged;
    set_in(k, 30'd0, 32'd0, 4'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) set_in(k, 30'h20, 32'h1234_5678, 4'b0010, 1'b1);
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_stall", k, 32'(stall[k]), 32'd0);
      check("rst_we", k, 32'(ram_we[k]), 32'd0);
      check("rst_re", k, 32'(ram_re[k]), 32'd0);
      check("rst_mdatai", k, mdatai[k], 32'd0);
    end
    for (int k = 0; k < 3; k++) set_in(k, 30'd0, 32'd0, 4'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read back at latency 1.
    run_op(0, 30'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
    check("full_wr_lit", 0, sram[0][8'h10], 32'hDEAD_BEEF);
    run_op(0, 30'h0, 32'h0, 4'h0, 1'b0, 0);
    run_op(0, 30'h10, 32'h0, 4'h0, 1'b1, 0);
    check("rd_lit", 0, last_mdatai, 32'hDEAD_BEEF);
    check("rd_stalls", 0, 32'(stall_cnt), 32'd1);

    // Byte store at latency 1.
    preload(0, 8'h20, 32'h1122_3344);
    run_op(0, 30'h20, 32'h00AA_0000, 4'b0100, 1'b0, 0);
    check("byte_st_lit", 0, sram[0][8'h20], 32'h11AA_3344);

    // Half-word store at latency 3.
    preload(2, 8'h40, 32'h1122_3344);
    run_op(2, 30'h40, 32'h0000_BBCC, 4'b0011, 1'b0, 0);
    check("half_st_stalls", 2, 32'(stall_cnt), 32'd3);
    check("half_st_lit", 2, sram[2][8'h40], 32'h1122_BBCC);
    run_op(2, 30'h40, 32'h0, 4'h0, 1'b1, 1);
    check("rd3_lit", 2, last_mdatai, 32'h1122_BBCC);

    // Read immediately followed by a full write.
    run_op(0, 30'h20, 32'h0, 4'h0, 1'b1, 0);
    check("b2b_rd_lit", 0, last_mdatai, 32'h11AA_3344);
    run_op(0, 30'h24, 32'hCAFE_F00D, 4'hF, 1'b0, 0);
    check("b2b_wr_lit", 0, sram[0][8'h24], 32'hCAFE_F00D);
    check("b2b_keep_lit", 0, sram[0][8'h20], 32'h11AA_3344);

    // MRE together with a strobe is a partial write; inputs wobble after the request cycle.
    preload(1, 8'h50, 32'hA0B0_C0D0);
    run_op(1, 30'h50, 32'h0000_00EE, 4'b0001, 1'b1, 1);
    check("mre_wstb_lit", 1, sram[1][8'h50], 32'hA0B0_C0EE);

    // Upper address bits beyond AW are dropped.
    run_op(1, 30'h2000_0051, 32'h0BAD_CAFE, 4'hF, 1'b0, 0);
    run_op(1, 30'h51, 32'h0, 4'h0, 1'b1, 0);
    check("wrap_lit", 1, last_mdatai, 32'h0BAD_CAFE);
    run_op(1, 30'h77, 32'h0, 4'b1000, 1'b0, 0);

    // Reset during MWAIT abandons the store.
    preload(1, 8'h30, 32'h5566_7788);
    set_in(1, 30'h30, 32'h0000_00FF, 4'b0001, 1'b0);
    @(posedge clk); #1;
    check("mwait_stall", 1, 32'(stall[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", 1, 32'(stall[1]), 32'd0);
    check("rst_mid_we", 1, 32'(ram_we[1]), 32'd0);
    @(negedge clk);
    set_in(1, 30'd0, 32'd0, 4'h0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) run_op(1, 30'h0, 32'h0, 4'h0, 1'b0, 0);
    check("rst_mid_mem", 1, sram[1][8'h30], 32'h5566_7788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
